// File: rtl/ysyx_22041211_lsu.sv
// Multi-cycle load/store unit sitting between EX and register write-back.
// It accepts one instruction at a time over a valid/ready handshake. It issues a
// single memory request over a valid/ready bus and steers the byte lanes for
// loads and stores. Load data is sign- or zero-extended, and accesses that are not
// aligned to their size are flagged without any bus activity. A transaction that
// gets no response within BUS_TIMEOUT cycles is terminated with a bus error.
// Non-memory instructions pass their ALU result through with one cycle of latency.
module ysyx_22041211_lsu #(
    parameter int DATA_LEN    = 32,
    parameter int BUS_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  wd_i,
    input  logic [4:0]            wreg_i,
    input  logic [DATA_LEN-1:0]   alu_result_i,
    input  logic [2:0]            load_type_i,
    input  logic [1:0]            store_type_i,
    input  logic [DATA_LEN-1:0]   store_data_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  wd_o,
    output logic [4:0]            wreg_o,
    output logic [DATA_LEN-1:0]   wdata_o,
    output logic                  misalign_o,
    output logic                  bus_err_o,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_wen,
    output logic [DATA_LEN-1:0]   mem_req_addr,
    output logic [DATA_LEN-1:0]   mem_req_wdata,
    output logic [DATA_LEN/8-1:0] mem_req_wstrb,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_LEN-1:0]   mem_rsp_rdata
);

    localparam int NB   = DATA_LEN / 8;
    localparam int LW   = $clog2(NB);
    localparam bit IS64 = (DATA_LEN == 64);

    // The counter only ever holds 0 .. BUS_TIMEOUT-1 before leaving REQ/WAIT.
    localparam int            TW         = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT);
    localparam bit            TIMEOUT_EN = (BUS_TIMEOUT != 0);
    localparam logic [TW-1:0] TO_LAST    = TW'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic                wd_reg,        wd_next;
    logic [4:0]          wreg_reg,      wreg_next;
    logic [DATA_LEN-1:0] result_reg,    result_next;
    logic                misalign_reg,  misalign_next;
    logic                bus_err_reg,   bus_err_next;
    logic                wen_reg,       wen_next;
    logic [DATA_LEN-1:0] addr_reg,      addr_next;
    logic [DATA_LEN-1:0] req_wdata_reg, req_wdata_next;
    logic [NB-1:0]       strb_reg,      strb_next;
    logic [2:0]          load_type_reg, load_type_next;
    logic [LW-1:0]       lane_reg,      lane_next;
    logic [TW-1:0]       cnt_reg,       cnt_next;

    // Decode of the incoming instruction (only meaningful in IDLE).
    logic                is_load;
    logic                is_mem;
    logic [3:0]          load_size;
    logic [3:0]          store_size;
    logic [3:0]          acc_size;
    logic                misaligned_in;
    logic [LW-1:0]       lane_in;
    logic [NB-1:0]       strb_in;
    logic [DATA_LEN-1:0] wdata_in;
    logic [DATA_LEN-1:0] addr_in;

    // Response path: selected lane extended according to the registered load type.
    logic [DATA_LEN-1:0] rsp_shifted;
    logic [DATA_LEN-1:0] load_ext;
    logic [DATA_LEN-1:0] capture_data;
    logic                timeout_hit;

    assign in_ready      = (state_reg == IDLE);
    assign out_valid     = (state_reg == RESP);
    assign mem_req_valid = (state_reg == REQ);
    assign mem_req_wen   = wen_reg;
    assign mem_req_addr  = addr_reg;
    assign mem_req_wdata = req_wdata_reg;
    assign mem_req_wstrb = strb_reg;
    assign wd_o          = wd_reg;
    assign wreg_o        = wreg_reg;
    assign wdata_o       = result_reg;
    assign misalign_o    = misalign_reg;
    assign bus_err_o     = bus_err_reg;

    // Access size in bytes for the incoming load/store; codes 6/7 fold onto LW at 32 bits.
    always_comb begin
        load_size = 4'd0;
        case (load_type_i)
            3'd1, 3'd4: load_size = 4'd1;
            3'd2, 3'd5: load_size = 4'd2;
            3'd3, 3'd7: load_size = 4'd4;
            3'd6:       load_size = IS64 ? 4'd8 : 4'd4;
            default:    load_size = 4'd0;
        endcase
        store_size = 4'd0;
        case (store_type_i)
            2'd1:    store_size = 4'd1;
            2'd2:    store_size = 4'd2;
            2'd3:    store_size = 4'(NB);
            default: store_size = 4'd0;
        endcase
    end

    // Request formation: a load wins when both types are set; lanes come from the low address bits.
    always_comb begin
        is_load  = (load_type_i != 3'd0);
        is_mem   = is_load || (store_type_i != 2'd0);
        acc_size = is_load ? load_size : store_size;
        lane_in  = alu_result_i[LW-1:0];
        addr_in  = {alu_result_i[DATA_LEN-1:LW], {LW{1'b0}}};
        misaligned_in = 1'b0;
        case (acc_size)
            4'd2:    misaligned_in = alu_result_i[0];
            4'd4:    misaligned_in = |alu_result_i[1:0];
            4'd8:    misaligned_in = |alu_result_i[2:0];
            default: misaligned_in = 1'b0;
        endcase
        strb_in  = NB'((32'd1 << acc_size) - 32'd1) << lane_in;
        wdata_in = store_data_i << {lane_in, 3'b000};
    end

    // Load extraction: shift the addressed lane down, then sign- or zero-extend it.
    always_comb begin
        rsp_shifted = mem_rsp_rdata >> {lane_reg, 3'b000};
        load_ext    = '0;
        case (load_type_reg)
            3'd1:    load_ext = DATA_LEN'($signed(rsp_shifted[7:0]));
            3'd2:    load_ext = DATA_LEN'($signed(rsp_shifted[15:0]));
            3'd3:    load_ext = DATA_LEN'($signed(rsp_shifted[31:0]));
            3'd4:    load_ext = DATA_LEN'(rsp_shifted[7:0]);
            3'd5:    load_ext = DATA_LEN'(rsp_shifted[15:0]);
            3'd6:    load_ext = IS64 ? rsp_shifted : DATA_LEN'($signed(rsp_shifted[31:0]));
            3'd7:    load_ext = IS64 ? DATA_LEN'(rsp_shifted[31:0])
                                     : DATA_LEN'($signed(rsp_shifted[31:0]));
            default: load_ext = '0;
        endcase
        capture_data = wen_reg ? '0 : load_ext;
        timeout_hit  = TIMEOUT_EN && (cnt_reg == TO_LAST);
    end

    // Next-state and datapath updates; every field holds unless a state says otherwise.
    always_comb begin
        state_next     = state_reg;
        wd_next        = wd_reg;
        wreg_next      = wreg_reg;
        result_next    = result_reg;
        misalign_next  = misalign_reg;
        bus_err_next   = bus_err_reg;
        wen_next       = wen_reg;
        addr_next      = addr_reg;
        req_wdata_next = req_wdata_reg;
        strb_next      = strb_reg;
        load_type_next = load_type_reg;
        lane_next      = lane_reg;
        cnt_next       = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    wd_next       = wd_i;
                    wreg_next     = wreg_i;
                    result_next   = '0;
                    misalign_next = 1'b0;
                    bus_err_next  = 1'b0;
                    if (!is_mem) begin
                        result_next = alu_result_i;
                        state_next  = RESP;
                    end else if (misaligned_in) begin
                        misalign_next = 1'b1;
                        wd_next       = 1'b0;
                        state_next    = RESP;
                    end else begin
                        wen_next       = !is_load;
                        addr_next      = addr_in;
                        req_wdata_next = is_load ? '0 : wdata_in;
                        strb_next      = is_load ? '0 : strb_in;
                        load_type_next = is_load ? load_type_i : 3'd0;
                        lane_next      = lane_in;
                        cnt_next       = '0;
                        state_next     = REQ;
                    end
                end
            end
            REQ: begin
                if (TIMEOUT_EN) begin
                    cnt_next = cnt_reg + TW'(1);
                end
                // A response arriving together with the handshake must not be lost.
                if (mem_req_ready && mem_rsp_valid) begin
                    result_next = capture_data;
                    state_next  = RESP;
                end else if (timeout_hit) begin
                    bus_err_next = 1'b1;
                    wd_next      = 1'b0;
                    result_next  = '0;
                    state_next   = RESP;
                end else if (mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (TIMEOUT_EN) begin
                    cnt_next = cnt_reg + TW'(1);
                end
                if (mem_rsp_valid) begin
                    result_next = capture_data;
                    state_next  = RESP;
                end else if (timeout_hit) begin
                    bus_err_next = 1'b1;
                    wd_next      = 1'b0;
                    result_next  = '0;
                    state_next   = RESP;
                end
            end
            RESP: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset abandons any transaction at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Registered instruction, request and result fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_reg        <= 1'b0;
            wreg_reg      <= 5'd0;
            result_reg    <= '0;
            misalign_reg  <= 1'b0;
            bus_err_reg   <= 1'b0;
            wen_reg       <= 1'b0;
            addr_reg      <= '0;
            req_wdata_reg <= '0;
            strb_reg      <= '0;
            load_type_reg <= 3'd0;
            lane_reg      <= '0;
            cnt_reg       <= '0;
        end else begin
            wd_reg        <= wd_next;
            wreg_reg      <= wreg_next;
            result_reg    <= result_next;
            misalign_reg  <= misalign_next;
            bus_err_reg   <= bus_err_next;
            wen_reg       <= wen_next;
            addr_reg      <= addr_next;
            req_wdata_reg <= req_wdata_next;
            strb_reg      <= strb_next;
            load_type_reg <= load_type_next;
            lane_reg      <= lane_next;
            cnt_reg       <= cnt_next;
        end
    end

endmodule

// File: tb/tb_ysyx_22041211_lsu.sv
// Directed bench for the load/store unit at DATA_LEN=32.
// The main instance uses the default timeout. A second instance with
// BUS_TIMEOUT=4 shares every input except in_valid and exercises the timeout.
module tb_ysyx_22041211_lsu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_valid2;
    logic        wd_i;
    logic [4:0]  wreg_i;
    logic [31:0] alu_result_i;
    logic [2:0]  load_type_i;
    logic [1:0]  store_type_i;
    logic [31:0] store_data_i;
    logic        out_ready;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    logic        in_ready,      in_ready2;
    logic        out_valid,     out_valid2;
    logic        wd_o,          wd_o2;
    logic [4:0]  wreg_o,        wreg_o2;
    logic [31:0] wdata_o,       wdata_o2;
    logic        misalign_o,    misalign_o2;
    logic        bus_err_o,     bus_err_o2;
    logic        mem_req_valid, mem_req_valid2;
    logic        mem_req_wen,   mem_req_wen2;
    logic [31:0] mem_req_addr,  mem_req_addr2;
    logic [31:0] mem_req_wdata, mem_req_wdata2;
    logic [3:0]  mem_req_wstrb, mem_req_wstrb2;

    int   n_cmp = 0;
    int   n_err = 0;
    logic seen_req;

    ysyx_22041211_lsu #(.DATA_LEN(32), .BUS_TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .wd_i(wd_i), .wreg_i(wreg_i), .alu_result_i(alu_result_i),
        .load_type_i(load_type_i), .store_type_i(store_type_i), .store_data_i(store_data_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
    );

    ysyx_22041211_lsu #(.DATA_LEN(32), .BUS_TIMEOUT(4)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .wd_i(wd_i), .wreg_i(wreg_i), .alu_result_i(alu_result_i),
        .load_type_i(load_type_i), .store_type_i(store_type_i), .store_data_i(store_data_i),
        .out_valid(out_valid2), .out_ready(out_ready),
        .wd_o(wd_o2), .wreg_o(wreg_o2), .wdata_o(wdata_o2),
        .misalign_o(misalign_o2), .bus_err_o(bus_err_o2),
        .mem_req_valid(mem_req_valid2), .mem_req_ready(mem_req_ready),
        .mem_req_wen(mem_req_wen2), .mem_req_addr(mem_req_addr2),
        .mem_req_wdata(mem_req_wdata2), .mem_req_wstrb(mem_req_wstrb2),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sticky record of any request cycle on the main instance.
    always @(negedge clk) begin
        if (mem_req_valid === 1'b1) seen_req = 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction to the main instance for a single cycle.
    task automatic issue(input logic [4:0] wreg, input logic [31:0] alu,
                         input logic [2:0] lt, input logic [1:0] st, input logic [31:0] sd);
        in_valid     = 1'b1;
        wd_i         = 1'b1;
        wreg_i       = wreg;
        alu_result_i = alu;
        load_type_i  = lt;
        store_type_i = st;
        store_data_i = sd;
        tick();
        in_valid = 1'b0;
    endtask

    // Zero-wait access: request accepted at once, response on the following cycle.
    task automatic mem_cycle(input logic [31:0] alu, input logic [2:0] lt, input logic [1:0] st,
                             input logic [31:0] sd, input logic [31:0] rdata);
        mem_req_ready = 1'b1;
        issue(5'd4, alu, lt, st, sd);
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rdata;
        tick();
        mem_rsp_valid = 1'b0;
        $display("txn addr=%h lt=%0d st=%0d rdata=%h -> out_valid=%b wdata=%h",
                 alu, lt, st, rdata, out_valid, wdata_o);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0; wd_i = 1'b0; wreg_i = 5'd0;
        alu_result_i = '0; load_type_i = '0; store_type_i = '0; store_data_i = '0;
        out_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
        seen_req = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_req_valid", mem_req_valid, 1'b0);
        chk("rst_wd", wd_o, 1'b0);
        chk("rst_wdata", wdata_o, 32'h0);
        chk("rst_addr", mem_req_addr, 32'h0);
        chk("rst_wstrb", mem_req_wstrb, 4'h0);
        rst_n = 1'b1;
        tick();

        // Pass-through with one cycle latency
        out_ready = 1'b1;
        seen_req = 1'b0;
        issue(5'd3, 32'h1234, 3'd0, 2'd0, 32'h0);
        $display("txn pass-through 0x1234 -> out_valid=%b wdata=%h", out_valid, wdata_o);
        chk("pt_out_valid", out_valid, 1'b1);
        chk("pt_wdata", wdata_o, 32'h1234);
        chk("pt_wd", wd_o, 1'b1);
        chk("pt_wreg", wreg_o, 5'd3);
        chk("pt_in_ready", in_ready, 1'b0);
        tick();
        chk("pt_done", out_valid, 1'b0);
        chk("pt_idle", in_ready, 1'b1);
        chk("pt_no_req", seen_req, 1'b0);

        // LB at 0x80000003 with request field checks
        mem_req_ready = 1'b1;
        issue(5'd4, 32'h8000_0003, 3'd1, 2'd0, 32'h0);
        chk("lb_req_valid", mem_req_valid, 1'b1);
        chk("lb_addr", mem_req_addr, 32'h8000_0000);
        chk("lb_wen", mem_req_wen, 1'b0);
        chk("lb_wstrb", mem_req_wstrb, 4'h0);
        tick();
        chk("lb_wait_req", mem_req_valid, 1'b0);
        chk("lb_wait_out", out_valid, 1'b0);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h80FF_FFFF;
        tick();
        mem_rsp_valid = 1'b0;
        $display("txn LB 0x80000003 rdata=80ffffff -> wdata=%h", wdata_o);
        chk("lb_out_valid", out_valid, 1'b1);
        chk("lb_wdata", wdata_o, 32'hFFFF_FF80);
        chk("lb_wd", wd_o, 1'b1);
        chk("lb_flags", {misalign_o, bus_err_o}, 2'b00);
        tick();

        // Remaining load extensions
        mem_cycle(32'h8000_0003, 3'd4, 2'd0, 32'h0, 32'h80FF_FFFF);
        chk("lbu_wdata", wdata_o, 32'h0000_0080);
        tick();
        mem_cycle(32'h8000_0002, 3'd2, 2'd0, 32'h0, 32'h8001_1234);
        chk("lh_wdata", wdata_o, 32'hFFFF_8001);
        tick();
        mem_cycle(32'h8000_0002, 3'd5, 2'd0, 32'h0, 32'h8001_1234);
        chk("lhu_wdata", wdata_o, 32'h0000_8001);
        tick();
        mem_cycle(32'h8000_0001, 3'd4, 2'd0, 32'h0, 32'h1122_3344);
        chk("lbu_lane1", wdata_o, 32'h0000_0033);
        tick();
        mem_cycle(32'h8000_0008, 3'd3, 2'd0, 32'h0, 32'hCAFE_F00D);
        chk("lw_wdata", wdata_o, 32'hCAFE_F00D);
        tick();
        mem_cycle(32'h8000_000C, 3'd7, 2'd0, 32'h0, 32'h8000_0001);
        chk("lwu32_wdata", wdata_o, 32'h8000_0001);
        tick();

        // SH at 0x80000002
        issue(5'd5, 32'h8000_0002, 3'd0, 2'd2, 32'h0000_ABCD);
        chk("sh_wstrb", mem_req_wstrb, 4'b1100);
        chk("sh_wdata", mem_req_wdata, 32'hABCD_0000);
        chk("sh_wen", mem_req_wen, 1'b1);
        chk("sh_addr", mem_req_addr, 32'h8000_0000);
        tick();
        chk("sh_wait_out", out_valid, 1'b0);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hFFFF_FFFF;
        tick();
        mem_rsp_valid = 1'b0;
        $display("txn SH 0x80000002 data=abcd -> out_valid=%b wdata=%h", out_valid, wdata_o);
        chk("sh_out_valid", out_valid, 1'b1);
        chk("sh_result", wdata_o, 32'h0);
        tick();

        // SB lane 1, SW aligned, and load priority over store
        issue(5'd5, 32'h8000_0001, 3'd0, 2'd1, 32'h1234_5678);
        $display("txn SB 0x80000001 -> wstrb=%b wdata=%h", mem_req_wstrb, mem_req_wdata);
        chk("sb_wstrb", mem_req_wstrb, 4'b0010);
        chk("sb_wdata", mem_req_wdata, 32'h3456_7800);
        tick(); mem_rsp_valid = 1'b1; tick(); mem_rsp_valid = 1'b0; tick();
        issue(5'd5, 32'h8000_0010, 3'd0, 2'd3, 32'h1234_5678);
        $display("txn SW 0x80000010 -> wstrb=%b wdata=%h", mem_req_wstrb, mem_req_wdata);
        chk("sw_wstrb", mem_req_wstrb, 4'b1111);
        chk("sw_wdata", mem_req_wdata, 32'h1234_5678);
        tick(); mem_rsp_valid = 1'b1; tick(); mem_rsp_valid = 1'b0; tick();
        issue(5'd6, 32'h8000_0000, 3'd3, 2'd3, 32'h0000_AAAA);
        $display("txn LW+SW 0x80000000 -> wen=%b wstrb=%b", mem_req_wen, mem_req_wstrb);
        chk("prio_wen", mem_req_wen, 1'b0);
        chk("prio_wstrb", mem_req_wstrb, 4'h0);
        tick(); mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0BAD_CAFE; tick(); mem_rsp_valid = 1'b0;
        chk("prio_wdata", wdata_o, 32'h0BAD_CAFE);
        tick();

        // Misaligned accesses never reach the bus
        seen_req = 1'b0;
        issue(5'd7, 32'h8000_0002, 3'd3, 2'd0, 32'h0);
        $display("txn LW 0x80000002 -> misalign=%b wd=%b", misalign_o, wd_o);
        chk("mis_out_valid", out_valid, 1'b1);
        chk("mis_flag", misalign_o, 1'b1);
        chk("mis_wd", wd_o, 1'b0);
        chk("mis_req_valid", mem_req_valid, 1'b0);
        tick();
        issue(5'd7, 32'h8000_0001, 3'd0, 2'd2, 32'h0);
        $display("txn SH 0x80000001 -> misalign=%b", misalign_o);
        chk("mis_sh_flag", misalign_o, 1'b1);
        tick();
        chk("mis_no_req", seen_req, 1'b0);

        // Request held under back-pressure, then response with the handshake
        out_ready = 1'b0;
        mem_req_ready = 1'b0;
        issue(5'd8, 32'h8000_0004, 3'd3, 2'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_req_valid", mem_req_valid, 1'b1);
            chk("bp_addr", mem_req_addr, 32'h8000_0004);
            chk("bp_wen", mem_req_wen, 1'b0);
            chk("bp_wstrb", mem_req_wstrb, 4'h0);
            tick();
        end
        chk("bp_still_req", mem_req_valid, 1'b1);
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h7654_3210;
        tick();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0;
        $display("txn LW 0x80000004 late ready -> out_valid=%b wdata=%h", out_valid, wdata_o);
        chk("bp_out_valid", out_valid, 1'b1);
        chk("bp_wdata", wdata_o, 32'h7654_3210);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_out_valid", out_valid, 1'b1);
            chk("hold_wdata", wdata_o, 32'h7654_3210);
            chk("hold_wreg", wreg_o, 5'd8);
        end
        out_ready = 1'b1;
        tick();
        chk("hold_done", out_valid, 1'b0);

        // Timeout on the short-timeout instance: no response ever arrives
        mem_req_ready = 1'b1;
        in_valid2 = 1'b1; wd_i = 1'b1; wreg_i = 5'd9; alu_result_i = 32'h10;
        load_type_i = 3'd3; store_type_i = 2'd0;
        tick();
        in_valid2 = 1'b0;
        chk("to_req_valid", mem_req_valid2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_pending", out_valid2, 1'b0);
        end
        tick();
        $display("txn timeout LW 0x10 -> out_valid=%b bus_err=%b wd=%b", out_valid2, bus_err_o2, wd_o2);
        chk("to_out_valid", out_valid2, 1'b1);
        chk("to_bus_err", bus_err_o2, 1'b1);
        chk("to_wd", wd_o2, 1'b0);
        chk("to_wdata", wdata_o2, 32'h0);
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h5555_5555;
        tick();
        mem_rsp_valid = 1'b0;
        chk("stray_out_valid", out_valid2, 1'b0);
        chk("stray_in_ready", in_ready2, 1'b1);

        // Asynchronous reset while waiting for a response
        issue(5'd10, 32'h8000_0020, 3'd3, 2'd0, 32'h0);
        tick();
        chk("rw_in_wait", {mem_req_valid, out_valid, in_ready}, 3'b000);
        #2 rst_n = 1'b0;
        #1;
        $display("txn reset in WAIT -> req_valid=%b out_valid=%b", mem_req_valid, out_valid);
        chk("rw_req_valid", mem_req_valid, 1'b0);
        chk("rw_out_valid", out_valid, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rw_in_ready", in_ready, 1'b1);

        // Asynchronous reset while the request is being presented
        mem_req_ready = 1'b0;
        issue(5'd11, 32'h8000_0024, 3'd3, 2'd0, 32'h0);
        chk("rr_req_before", mem_req_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        $display("txn reset in REQ -> req_valid=%b", mem_req_valid);
        chk("rr_req_valid", mem_req_valid, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rr_in_ready", in_ready, 1'b1);
        chk("rr_out_valid", out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
